midi_tx: RTL and testbench
==========================

// Module: midi_tx
// PURPOSE
//   MIDI transmitter: accepts one note event per handshake and formats it as a 3-byte MIDI
//   channel message (status, note, velocity). Serialises it as 8N1 UART at BAUD on midi_tx_ttl.
//   Transmit-side counterpart of the MIDI receive/parse path. Used for MIDI-thru/out and
//   as a loopback stimulus source.
// PARAMETERS
//   CLK_HZ       50_000_000  system clock frequency (Hz)
//   BAUD         31_250      serial bit rate; BIT_CYC = CLK_HZ/BAUD (1600 at defaults)
//   INVERT_MIDI  0           1: drive ~line (idle low) on midi_tx_ttl
// PORTS
//   clk_50m      in   1  system clock
//   rst_n        in   1  asynchronous, active-low reset
//   ev_valid     in   1  event offered
//   ev_ready     out  1  block can accept event (high only in IDLE)
//   ev_on        in   1  1 = note-on, 0 = note-off
//   ev_chan      in   4  MIDI channel 0..15
//   ev_note      in   7  note number 0..127
//   ev_vel       in   7  velocity 0..127
//   midi_tx_ttl  out  1  serial MIDI out (idle high unless INVERT_MIDI)
//   busy         out  1  message in flight (== ~ev_ready)
// BEHAVIOUR
//   - Reset (async): line idle (1, or 0 if INVERT_MIDI); ev_ready=1; busy=0; bit counter,
//     cycle divider and byte index cleared; last_status=8'h00 (invalid). Reset during a message
//     drops it; line returns to idle the same instant.
//   - Accept: ev_valid && ev_ready on a rising edge. Capture chan/note/vel/on into holding regs.
//     ev_ready drops next cycle. Inputs are don't-care afterwards.
//   - Status byte: note-on = 8'h90|chan, data2 = vel. Note-off = 8'h80|chan, data2 = 8'h00.
//     Data bytes are {1'b0, note}, {1'b0, vel}; bit 7 of data bytes is always 0.
//   - Message FSM: IDLE -> SEND_STATUS -> SEND_D1 -> SEND_D2 -> IDLE. Each SEND state runs the
//     byte engine once and advances when the stop bit completes.
//   - Byte engine: start(0), d0..d7 LSB first, stop(1). Each bit is held exactly BIT_CYC cycles
//     via a divider counting BIT_CYC-1 down to 0. 10 bit times per byte.
//   - Timing: start bit is driven on the cycle after accept. Bytes are back-to-back with no idle
//     gap. A full 3-byte message takes 30*BIT_CYC cycles (48000 at defaults). ev_ready rises
//     in the cycle after the final stop bit ends; a new accept in that cycle starts the next
//     start bit one cycle later.
//   - ev_valid while busy is ignored (not queued). The source must hold it until ready.
//   - last_status is updated to the status value each time a message is accepted.
//   - The divider is free of wrap hazards: it reloads on every bit boundary, and the bit index
//     saturates at stop, then resets.
// CONFIGURATION
//   MIDI_TX_RUNNING_STATUS_EN defined:
//     - note-off is sent as 8'h90|chan with data2 = 8'h00.
//     - If the computed status equals last_status, SEND_STATUS is skipped: the message is
//       2 bytes, 20*BIT_CYC cycles, and the start bit of data1 follows accept by one cycle.
//     - last_status resets to 8'h00, so the first message always carries its status.
//   Not defined: every message carries its status byte; note-off uses 8'h8n. last_status is
//     kept but unused.
// TESTING
//   1 Reset, then event on=1 chan=0 note=60 vel=100 -> line bytes 90 3C 64, 8N1 LSB-first,
//     each bit 1600 cyc. ev_ready low for 48000 cyc, then high.
//   2 on=0 chan=1 note=64 vel=90 -> bytes 81 40 00 (macro off); 91 40 00 (macro on).
//   3 Two note-ons on chan 2 issued back-to-back at ready -> macro off: 92 xx xx 92 yy yy with
//     no idle gap. Macro on: 92 xx xx yy yy, second message 32000 cyc.
//   4 Hold ev_valid with changing data while busy -> only the first event appears on the line.
//     Capture is verified by changing inputs after accept.
//   5 Assert rst_n low mid data1 -> line idle immediately, ev_ready=1. After release the next
//     event is sent complete; with the macro on it includes its status byte.
//   6 INVERT_MIDI=1 -> idle low and all levels inverted. Loop midi_tx_ttl into the MIDI
//     receiver: decoded note/vel must match the sent event.

Source files
------------

// File: rtl/midi_tx.sv
// ---------------------------------------------------------------------------
// midi_tx
//   MIDI transmitter. Takes one note event per valid/ready handshake, builds a
//   3-byte channel message (status, note, velocity) and shifts it out as 8N1
//   UART at BAUD on midi_tx_ttl.
//
// Ports
//   clk_50m      in   system clock
//   rst_n        in   asynchronous active-low reset
//   ev_valid     in   event offered
//   ev_ready     out  event can be accepted (high only while idle)
//   ev_on        in   1 = note-on, 0 = note-off
//   ev_chan      in   MIDI channel 0..15
//   ev_note      in   note number 0..127
//   ev_vel       in   velocity 0..127
//   midi_tx_ttl  out  serial MIDI out (idle high, idle low when INVERT_MIDI=1)
//   busy         out  message in flight (inverse of ev_ready)
//
// Build option
//   MIDI_TX_RUNNING_STATUS_EN : when defined, note-off is sent as 9n/vel 0 and
//   the status byte is omitted when it equals the last accepted status.
// ---------------------------------------------------------------------------
module midi_tx #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 31_250,
    parameter int INVERT_MIDI = 0
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [3:0] ev_chan,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_vel,
    output logic       midi_tx_ttl,
    output logic       busy
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int DIV_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BIT_CYC - 1);

    // Bit index within a byte: 0 = start, 1..8 = data LSB first, 9 = stop.
    localparam logic [3:0] BIT_LAST_DATA = 4'd8;
    localparam logic [3:0] BIT_STOP      = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATUS,
        S_D1,
        S_D2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_idx;
    logic             line_q;       // logical line level, 1 = idle/mark
    logic             ev_ready_q;
    logic [7:0]       last_status;  // also holds the status byte of the message in flight
    logic [7:0]       d1_q;
    logic [7:0]       d2_q;

    logic [7:0]       status_w;
    logic [7:0]       d2_w;
    logic             skip_status_w;
    logic [7:0]       tx_byte;
    logic             accept;

    assign accept = ev_valid && ev_ready_q;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    // Note-off travels as note-on with velocity 0 so consecutive events on
    // one channel share a status byte.
    assign status_w      = {4'h9, ev_chan};
    assign d2_w          = ev_on ? {1'b0, ev_vel} : 8'h00;
    assign skip_status_w = (status_w == last_status);
`else
    assign status_w      = {(ev_on ? 4'h9 : 4'h8), ev_chan};
    assign d2_w          = ev_on ? {1'b0, ev_vel} : 8'h00;
    assign skip_status_w = 1'b0;
`endif

    always_comb begin
        tx_byte = last_status;
        unique case (state)
            S_D1:    tx_byte = d1_q;
            S_D2:    tx_byte = d2_q;
            default: tx_byte = last_status;
        endcase
    end

    // Event capture: payload only, no reset needed.
    always_ff @(posedge clk_50m) begin
        if (accept) begin
            d1_q <= {1'b0, ev_note};
            d2_q <= d2_w;
        end
    end

    // Message sequencer and byte engine.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_idx     <= '0;
            line_q      <= 1'b1;
            ev_ready_q  <= 1'b1;
            last_status <= 8'h00;
        end else if (state == S_IDLE) begin
            if (accept) begin
                last_status <= status_w;
                ev_ready_q  <= 1'b0;
                div_cnt     <= DIV_RELOAD;
                bit_idx     <= '0;
                line_q      <= 1'b0;   // start bit goes out the cycle after accept
                state       <= skip_status_w ? S_D1 : S_STATUS;
            end
        end else begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else begin
                div_cnt <= DIV_RELOAD;
                if (bit_idx == BIT_STOP) begin
                    // Stop bit done: next byte starts immediately, no idle gap.
                    bit_idx <= '0;
                    if (state == S_STATUS) begin
                        state  <= S_D1;
                        line_q <= 1'b0;
                    end else if (state == S_D1) begin
                        state  <= S_D2;
                        line_q <= 1'b0;
                    end else begin
                        state      <= S_IDLE;
                        line_q     <= 1'b1;
                        ev_ready_q <= 1'b1;
                    end
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                    line_q  <= (bit_idx == BIT_LAST_DATA) ? 1'b1 : tx_byte[bit_idx[2:0]];
                end
            end
        end
    end

    assign midi_tx_ttl = (INVERT_MIDI != 0) ? ~line_q : line_q;
    assign ev_ready    = ev_ready_q;
    assign busy        = ~ev_ready_q;

endmodule

// File: tb/tb_midi_tx.sv
module tb_midi_tx;

    localparam int CLK_HZ_TB = 50_000_000;
    localparam int BAUD_TB   = 3_125_000;
    localparam int BIT       = CLK_HZ_TB / BAUD_TB;   // 16 cycles per bit
    localparam int HALF      = BIT / 2;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;

    logic       ev_valid0 = 1'b0, ev_on0 = 1'b0;
    logic [3:0] ev_chan0 = '0;
    logic [6:0] ev_note0 = '0, ev_vel0 = '0;
    logic       ev_ready0, midi_tx_ttl0, busy0;

    logic       ev_valid1 = 1'b0, ev_on1 = 1'b0;
    logic [3:0] ev_chan1 = '0;
    logic [6:0] ev_note1 = '0, ev_vel1 = '0;
    logic       ev_ready1, midi_tx_ttl1, busy1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    midi_tx #(.CLK_HZ(CLK_HZ_TB), .BAUD(BAUD_TB), .INVERT_MIDI(0)) u_dut0 (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .ev_valid(ev_valid0), .ev_ready(ev_ready0), .ev_on(ev_on0),
        .ev_chan(ev_chan0), .ev_note(ev_note0), .ev_vel(ev_vel0),
        .midi_tx_ttl(midi_tx_ttl0), .busy(busy0)
    );

    midi_tx #(.CLK_HZ(CLK_HZ_TB), .BAUD(BAUD_TB), .INVERT_MIDI(1)) u_dut1 (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .ev_valid(ev_valid1), .ev_ready(ev_ready1), .ev_on(ev_on1),
        .ev_chan(ev_chan1), .ev_note(ev_note1), .ev_vel(ev_vel1),
        .midi_tx_ttl(midi_tx_ttl1), .busy(busy1)
    );

    // Serial receivers: channel 0 decodes DUT0, channel 1 decodes inverted DUT1.
    logic [7:0] q0[$], q1[$];
    int         t0q[$];
    int         ferr0 = 0, ferr1 = 0;
    bit         m_act[2];
    int         m_cnt[2];
    int         m_t0[2];
    logic [7:0] m_sh[2];
    bit         m_ok[2];

    initial begin
        logic lvl;
        int   k;
        m_act[0] = 0;
        m_act[1] = 0;
        forever begin
            @(negedge clk_50m);
            for (int ch = 0; ch < 2; ch++) begin
                lvl = (ch == 0) ? midi_tx_ttl0 : ~midi_tx_ttl1;
                if (!rst_n) begin
                    m_act[ch] = 0;
                end else if (!m_act[ch]) begin
                    if (lvl === 1'b0) begin
                        m_act[ch] = 1;
                        m_cnt[ch] = 0;
                        m_t0[ch]  = cyc;
                        m_ok[ch]  = 1;
                    end
                end else begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                    if ((m_cnt[ch] % BIT) == HALF) begin
                        k = m_cnt[ch] / BIT;
                        if (k == 0) begin
                            if (lvl !== 1'b0) m_ok[ch] = 0;
                        end else if (k <= 8) begin
                            m_sh[ch][k-1] = lvl;
                        end else begin
                            if (lvl !== 1'b1) m_ok[ch] = 0;
                            if (ch == 0) begin
                                q0.push_back(m_sh[ch]);
                                t0q.push_back(m_t0[ch]);
                                if (!m_ok[ch]) ferr0++;
                            end else begin
                                q1.push_back(m_sh[ch]);
                                if (!m_ok[ch]) ferr1++;
                            end
                            m_act[ch] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int dut, input logic on, input logic [3:0] ch,
                        input logic [6:0] nt, input logic [6:0] vl, input bit hold,
                        output int acc);
        bit r;
        bit done = 0;
        if (dut == 0) begin
            ev_on0 = on; ev_chan0 = ch; ev_note0 = nt; ev_vel0 = vl; ev_valid0 = 1'b1;
        end else begin
            ev_on1 = on; ev_chan1 = ch; ev_note1 = nt; ev_vel1 = vl; ev_valid1 = 1'b1;
        end
        for (int i = 0; i < 2000; i++) begin
            r = (dut == 0) ? ev_ready0 : ev_ready1;
            @(posedge clk_50m);
            #1;
            if (r) begin
                done = 1;
                break;
            end
        end
        if (!hold) begin
            ev_valid0 = 1'b0;
            ev_valid1 = 1'b0;
        end
        acc = cyc;
        check("accept_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_ready(input int dut, output int rc);
        bit got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_50m);
            #1;
            if (((dut == 0) ? ev_ready0 : ev_ready1) === 1'b1) begin
                got = 1;
                break;
            end
        end
        rc = cyc;
        check("ready_return", {31'd0, got}, 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp_b[$]);
        check({tag, "_count"}, q0.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            check($sformatf("%s_byte%0d", tag, i),
                  (i < q0.size()) ? {24'd0, q0[i]} : 32'h1FF, {24'd0, exp_b[i]});
        check({tag, "_framing"}, ferr0, 0);
    endtask

    initial begin
        int acc, acc2, rc, rc2;
        logic [7:0] exp_b[$];

        // Reset state
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_line0", {31'd0, midi_tx_ttl0}, 32'd1);
        check("rst_ready", {31'd0, ev_ready0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_line1_inv", {31'd0, midi_tx_ttl1}, 32'd0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        @(posedge clk_50m);
        #1;
        check("idle_line0", {31'd0, midi_tx_ttl0}, 32'd1);

        // 1: note-on ch0 note 60 vel 100
        q0.delete(); t0q.delete();
        send(0, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, acc);
        check("t1_ready_low", {31'd0, ev_ready0}, 32'd0);
        check("t1_busy_high", {31'd0, busy0}, 32'd1);
        wait_ready(0, rc);
        check("t1_duration", rc - acc, 30 * BIT);
        check("t1_busy_low", {31'd0, busy0}, 32'd0);
        exp_b = '{8'h90, 8'h3C, 8'h64};
        check_rx("t1", exp_b);
        check("t1_start0", (t0q.size() > 0) ? t0q[0] : -1, acc);
        check("t1_start1", (t0q.size() > 1) ? t0q[1] : -1, acc + 10 * BIT);
        check("t1_start2", (t0q.size() > 2) ? t0q[2] : -1, acc + 20 * BIT);

        // 2: note-off ch1 note 64 vel 90
        q0.delete(); t0q.delete();
        send(0, 1'b0, 4'd1, 7'd64, 7'd90, 1'b0, acc);
        wait_ready(0, rc);
        check("t2_duration", rc - acc, 30 * BIT);
        exp_b = RS ? '{8'h91, 8'h40, 8'h00} : '{8'h81, 8'h40, 8'h00};
        check_rx("t2", exp_b);

        // 3: two note-ons on ch2 back-to-back
        q0.delete(); t0q.delete();
        send(0, 1'b1, 4'd2, 7'd67, 7'd80, 1'b0, acc);
        wait_ready(0, rc);
        send(0, 1'b1, 4'd2, 7'd72, 7'd70, 1'b0, acc2);
        check("t3_reaccept", acc2 - rc, 1);
        wait_ready(0, rc2);
        check("t3_dur1", rc - acc, 30 * BIT);
        check("t3_dur2", rc2 - acc2, RS ? 20 * BIT : 30 * BIT);
        exp_b = RS ? '{8'h92, 8'h43, 8'h50, 8'h48, 8'h46}
                   : '{8'h92, 8'h43, 8'h50, 8'h92, 8'h48, 8'h46};
        check_rx("t3", exp_b);
        check("t3_start2nd", (t0q.size() > 3) ? t0q[3] : -1, acc2);

        // 4: hold ev_valid with changing data while busy
        q0.delete(); t0q.delete();
        send(0, 1'b1, 4'd3, 7'd10, 7'd20, 1'b1, acc);
        for (int i = 0; i < 25 * BIT; i++) begin
            ev_on0   = i[0];
            ev_chan0 = 4'(i + 5);
            ev_note0 = 7'(i * 3 + 99);
            ev_vel0  = 7'(i + 11);
            @(posedge clk_50m);
            #1;
        end
        check("t4_ready_held_low", {31'd0, ev_ready0}, 32'd0);
        ev_valid0 = 1'b0;
        wait_ready(0, rc);
        check("t4_duration", rc - acc, 30 * BIT);
        repeat (3 * BIT) @(posedge clk_50m);
        #1;
        exp_b = '{8'h93, 8'h0A, 8'h14};
        check_rx("t4", exp_b);

        // 5: reset during data1
        q0.delete(); t0q.delete();
        send(0, 1'b1, 4'd4, 7'd50, 7'd60, 1'b0, acc);
        repeat (15 * BIT) @(posedge clk_50m);
        #1;
        check("t5_busy_before", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_line", {31'd0, midi_tx_ttl0}, 32'd1);
        check("t5_rst_ready", {31'd0, ev_ready0}, 32'd1);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b1;
        @(posedge clk_50m);
        #1;
        repeat (2 * BIT) @(posedge clk_50m);
        #1;
        exp_b = '{8'h94};
        check_rx("t5_partial", exp_b);
        q0.delete(); t0q.delete();
        send(0, 1'b1, 4'd4, 7'd50, 7'd60, 1'b0, acc);
        wait_ready(0, rc);
        check("t5_duration", rc - acc, 30 * BIT);
        exp_b = '{8'h94, 8'h32, 8'h3C};
        check_rx("t5", exp_b);

        // 6: inverted output decoded by the receiver
        check("t6_idle_low", {31'd0, midi_tx_ttl1}, 32'd0);
        send(1, 1'b1, 4'd5, 7'd33, 7'd127, 1'b0, acc);
        check("t6_start_low_inv", {31'd0, midi_tx_ttl1}, 32'd1);
        wait_ready(1, rc);
        check("t6_duration", rc - acc, 30 * BIT);
        check("t6_count", q1.size(), 3);
        check("t6_status", (q1.size() > 0) ? {24'd0, q1[0]} : 32'h1FF, 32'h95);
        check("t6_note", (q1.size() > 1) ? {24'd0, q1[1]} : 32'h1FF, 32'd33);
        check("t6_vel", (q1.size() > 2) ? {24'd0, q1[2]} : 32'h1FF, 32'd127);
        check("t6_framing", ferr1, 0);
        check("t6_idle_after", {31'd0, midi_tx_ttl1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
